// File: rtl/tlc1543_pkg.sv
// Shared types and constants for the TLC1543 responder model.
// Holds the FSM state enum, the self-test address/code constants and the
// sample selection helper used when a conversion is started.
package tlc1543_pkg;

    localparam int TLC_BITS      = 10;
    localparam int TLC_ADDR_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2
    } state_t;

    localparam logic [TLC_ADDR_BITS-1:0] ADDR_REF_HALF = 4'hB;
    localparam logic [TLC_ADDR_BITS-1:0] ADDR_REF_LO   = 4'hC;
    localparam logic [TLC_ADDR_BITS-1:0] ADDR_REF_HI   = 4'hD;

    localparam logic [TLC_BITS-1:0] CODE_HALF = 10'h200;
    localparam logic [TLC_BITS-1:0] CODE_LO   = 10'h000;
    localparam logic [TLC_BITS-1:0] CODE_HI   = 10'h3FF;

    // Addresses 0..A are analog inputs; B..D are internal references and
    // E/F (power-down / unused) read back as zero.
    function automatic logic [TLC_BITS-1:0] sample_map(
        input logic [TLC_ADDR_BITS-1:0] addr,
        input logic [TLC_BITS-1:0]      value
    );
        logic [TLC_BITS-1:0] code;
        if (addr == ADDR_REF_HALF)      code = CODE_HALF;
        else if (addr == ADDR_REF_LO)   code = CODE_LO;
        else if (addr == ADDR_REF_HI)   code = CODE_HI;
        else if (addr > ADDR_REF_HI)    code = CODE_LO;
        else                            code = value;
        return code;
    endfunction

endpackage

// File: rtl/tlc1543_adc_model_if.sv
// Pin-level bus between a TLC1543 controller and the ADC (or this model).
// Signals: tlc1543_clk (I/O CLOCK), tlc1543_cs_n, tlc1543_addr (controller
// driven), tlc1543_data, tlc1543_eoc (ADC driven).
// master = controller side, slave = ADC side.
interface tlc1543_adc_model_if;
    logic tlc1543_clk;
    logic tlc1543_cs_n;
    logic tlc1543_addr;
    logic tlc1543_data;
    logic tlc1543_eoc;

    modport master (
        output tlc1543_clk, tlc1543_cs_n, tlc1543_addr,
        input  tlc1543_data, tlc1543_eoc
    );

    modport slave (
        input  tlc1543_clk, tlc1543_cs_n, tlc1543_addr,
        output tlc1543_data, tlc1543_eoc
    );
endinterface

// File: rtl/tlc_pin_sync.sv
// Input synchronizer with edge detection for one asynchronous pin.
// Ports: clk, rst_n (async active-low), pin (raw input),
//        level (synchronized value), rise/fall (one-cycle edge pulses).
// RST_VAL sets the idle level assumed during reset so releasing reset does
// not fabricate an edge on pins that idle high.
module tlc_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/tlc1543_adc_model.sv
// Synthesizable responder model of the TLC1543 10-bit serial ADC.
// Ports: clk_50m, rst_n (async active-low), pins (slave modport: I/O CLOCK,
//        CS, ADDRESS in; DATA OUT, EOC out), adc_ch_addr (channel to look
//        up), adc_ch_value (looked-up analog value), proto_err (sticky).
// Optional macro TLC1543_PROTO_CHK_EN builds the protocol checker that
// drives proto_err; without it proto_err is constant 0.
module tlc1543_adc_model
    import tlc1543_pkg::*;
#(
    parameter int CONV_CYCLES = 1050,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    tlc1543_adc_model_if.slave       pins,
    output logic [TLC_ADDR_BITS-1:0] adc_ch_addr,
    input  logic [TLC_BITS-1:0]      adc_ch_value,
    output logic                     proto_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic addr_lvl, addr_rise, addr_fall;

    tlc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk_50m), .rst_n(rst_n), .pin(pins.tlc1543_clk),
        .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
    );
    tlc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_50m), .rst_n(rst_n), .pin(pins.tlc1543_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    tlc_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_addr (
        .clk(clk_50m), .rst_n(rst_n), .pin(pins.tlc1543_addr),
        .level(addr_lvl), .rise(addr_rise), .fall(addr_fall)
    );

    state_t                   state, state_d;
    logic [3:0]               bit_cnt, bit_cnt_d, cnt_inc, bit_idx;
    logic [TLC_ADDR_BITS-1:0] addr_sr, addr_sr_d, ch_addr_d;
    logic [TLC_BITS-1:0]      result_q, result_d, sample_q, sample_d;
    logic [CNT_W-1:0]         conv_cnt, conv_cnt_d;
    logic                     data_q, data_d, eoc_q, eoc_d;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            addr_sr     <= '0;
            adc_ch_addr <= '0;
            result_q    <= '0;
            sample_q    <= '0;
            conv_cnt    <= '0;
            data_q      <= 1'b0;
            eoc_q       <= 1'b1;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            addr_sr     <= addr_sr_d;
            adc_ch_addr <= ch_addr_d;
            result_q    <= result_d;
            sample_q    <= sample_d;
            conv_cnt    <= conv_cnt_d;
            data_q      <= data_d;
            eoc_q       <= eoc_d;
        end
    end

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        addr_sr_d  = addr_sr;
        ch_addr_d  = adc_ch_addr;
        result_d   = result_q;
        sample_d   = sample_q;
        conv_cnt_d = conv_cnt;
        data_d     = data_q;
        eoc_d      = eoc_q;
        cnt_inc    = bit_cnt + 4'd1;
        bit_idx    = 4'd9 - cnt_inc;

        unique case (state)
            IDLE: begin
                data_d = 1'b0;
                if (cs_fall) begin
                    bit_cnt_d = '0;
                    data_d    = result_q[TLC_BITS-1];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A CS rise takes priority over a coincident clock fall.
                if (cs_rise) begin
                    data_d  = 1'b0;
                    state_d = IDLE;
                end else if (clk_rise) begin
                    if (bit_cnt < 4'd4)
                        addr_sr_d = {addr_sr[TLC_ADDR_BITS-2:0], addr_lvl};
                end else if (clk_fall) begin
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc < 4'd10)
                        data_d = result_q[bit_idx];
                    if (cnt_inc == 4'd4)
                        ch_addr_d = addr_sr;
                    if (cnt_inc == 4'd10) begin
                        sample_d   = sample_map(adc_ch_addr, adc_ch_value);
                        eoc_d      = 1'b0;
                        conv_cnt_d = '0;
                        state_d    = CONV;
                    end
                end
            end
            CONV: begin
                if (conv_cnt == CONV_LAST) begin
                    result_d = sample_q;
                    eoc_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    conv_cnt_d = conv_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pins.tlc1543_data = data_q;
    assign pins.tlc1543_eoc  = eoc_q;

`ifdef TLC1543_PROTO_CHK_EN
    logic proto_hit, proto_q;

    always_comb begin
        proto_hit = 1'b0;
        if (state == SHIFT && cs_rise)
            proto_hit = 1'b1;
        if (state == CONV && (cs_fall || clk_rise || clk_fall))
            proto_hit = 1'b1;
        if (state == IDLE && cs_lvl && (clk_rise || clk_fall))
            proto_hit = 1'b1;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) proto_q <= 1'b0;
        else        proto_q <= proto_q | proto_hit;
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

    // Levels/edges not needed by the functional path.
    logic unused_sync;
    assign unused_sync = &{1'b0, clk_lvl, cs_lvl, addr_rise, addr_fall};

endmodule
